uart_transmitter: RTL
=====================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter DATA_W, default 8: payload bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16: sample_ENABLE pulses per bit period; SHALL be a power of two, at most 16.
REQ-003 Port clk, input, 1: single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port sample_ENABLE, input, 1: one-clk-wide oversample tick from the baud controller.
REQ-006 Port Tx_DATA, input, DATA_W: payload; sampled only on accept.
REQ-007 Port Tx_WR, input, 1: write request.
REQ-008 Port TxD, output, 1: serial line, idle high.
REQ-009 Port Tx_BUSY, output, 1: high while a frame is in progress.

Function
REQ-010 Accept SHALL occur on a clk edge with Tx_WR=1 and Tx_BUSY=0; Tx_DATA latched into a shift register, Tx_BUSY=1 from the next cycle.
REQ-011 Tx_WR while Tx_BUSY=1 SHALL be ignored (no latch, no error).
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-013 IDLE->START on accept; START->DATA, DATA->PARITY or STOP, PARITY->STOP, STOP->IDLE, each on bit-period end.
REQ-014 Bit-period end SHALL be a cycle with sample_ENABLE=1 and oversample counter = OVERSAMPLE-1; the counter SHALL wrap to 0 there.
REQ-015 Oversample counter SHALL advance only on sample_ENABLE=1 and SHALL hold during gaps between ticks.
REQ-016 Oversample counter and bit index SHALL clear to 0 on accept.
REQ-017 TxD SHALL be registered: 1 in IDLE, 0 in START, shift-register bit 0 in DATA (LSB first), parity in PARITY, 1 in STOP.
REQ-018 DATA SHALL last exactly DATA_W bit periods; bit index counts 0..DATA_W-1, shift right at each bit-period end.
REQ-019 Tx_BUSY SHALL deassert in the cycle after the STOP bit-period end; a Tx_WR in that cycle SHALL be accepted (back-to-back, no idle bit).
REQ-020 Frame length SHALL be (DATA_W+2) x OVERSAMPLE ticks, plus OVERSAMPLE with parity.

Reset
REQ-021 reset=0 SHALL immediately force state=IDLE, TxD=1, Tx_BUSY=0, counters=0, shift register=0, including mid-frame.
REQ-022 After reset release, the first accept SHALL be possible on the first clk edge.

Configuration
REQ-023 Macro UART_TX_PARITY_EN defined: PARITY state present, bit = even parity (XOR of the latched payload).
REQ-024 UART_TX_PARITY_EN undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Structure
REQ-025 Package uart_pkg SHALL hold the FSM state enum, default DATA_W and OVERSAMPLE constants, and TxD idle/start/stop level constants.
REQ-026 Sub-module uart_tx_counter SHALL hold the oversample counter and bit index (clear, enable, bit-end and last-bit outputs).

Verification
REQ-027 Parity on, sample_ENABLE every cycle, write 0xA5 -> TxD = 0,1,0,1,0,0,1,0,1,0,1, each held 16 cycles; Tx_BUSY high 176 cycles.
REQ-028 Parity off, write 0x00 -> TxD low 144 cycles, then high 16 cycles; Tx_BUSY high 160 cycles.
REQ-029 sample_ENABLE every 4th cycle, write 0xFF -> each bit held 64 cycles; parity bit = 0.
REQ-030 Write 0x12; Tx_WR=1 with 0x34 mid-frame -> only 0x12 sent; Tx_WR with 0x34 in the cycle Tx_BUSY falls -> 0x34 start bit directly follows the 0x12 stop bit.
REQ-031 reset=0 during DATA bit 3 -> TxD=1 and Tx_BUSY=0 without a clk edge; a new write of 0x5A then sends a complete correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter slice.
// Holds the FSM state enum, default frame geometry and TxD line levels.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_OVERSAMPLE = 16;

    localparam logic TXD_IDLE  = 1'b1;
    localparam logic TXD_START = 1'b0;
    localparam logic TXD_STOP  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } tx_state_e;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: write port, oversample tick and serial output.
// master: drives Tx_DATA/Tx_WR/sample_ENABLE; slave: drives TxD/Tx_BUSY.
interface uart_transmitter_if
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) ();

    logic [DATA_W-1:0] Tx_DATA;
    logic              Tx_WR;
    logic              sample_ENABLE;
    logic              TxD;
    logic              Tx_BUSY;

    modport master (
        output Tx_DATA, Tx_WR, sample_ENABLE,
        input  TxD, Tx_BUSY
    );

    modport slave (
        input  Tx_DATA, Tx_WR, sample_ENABLE,
        output TxD, Tx_BUSY
    );

endinterface

// File: rtl/uart_tx_counter.sv
// uart_tx_counter: oversample counter and data bit index.
// Ports: clr (accept), en (tick while busy), bit_adv; out bit_end, last_bit.
module uart_tx_counter
    import uart_pkg::*;
#(
    parameter int DATA_W     = UART_DATA_W,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic bit_adv,
    output logic bit_end,
    output logic last_bit
);

    localparam int CNT_W = clog2_min1(OVERSAMPLE);
    localparam int IDX_W = clog2_min1(DATA_W);
    localparam logic [CNT_W-1:0] OS_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;

    assign bit_end  = en && (os_cnt_q == OS_LAST);
    assign last_bit = (bit_idx_q == IDX_LAST);

    always_comb begin
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        if (clr) begin
            os_cnt_d  = '0;
            bit_idx_d = '0;
        end else begin
            // Holds between ticks; wraps at the bit-period end.
            if (en) begin
                os_cnt_d = bit_end ? '0 : os_cnt_q + 1'b1;
            end
            if (bit_adv) begin
                bit_idx_d = last_bit ? '0 : bit_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
        end else begin
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: start, DATA_W bits LSB first, optional parity, stop.
// Ports: clk, reset (async, active-low), bus (slave). Macro UART_TX_PARITY_EN.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_W     = UART_DATA_W,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                clk,
    input  logic                reset,
    uart_transmitter_if.slave   bus
);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              busy;
    logic              accept;
    logic              bit_end;
    logic              last_bit;
    logic              bit_adv;

`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign busy        = (state_q != IDLE);
    assign accept      = bus.Tx_WR && !busy;
    assign bit_adv     = bit_end && (state_q == DATA);
    assign bus.Tx_BUSY = busy;
    assign bus.TxD     = txd_q;

    uart_tx_counter #(
        .DATA_W     (DATA_W),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (accept),
        .en       (bus.sample_ENABLE && busy),
        .bit_adv  (bit_adv),
        .bit_end  (bit_end),
        .last_bit (last_bit)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shift_d = bus.Tx_DATA;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.Tx_DATA;
`endif
                end
            end
            START: if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP: if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // TxD is registered from the next state so it lines up with state_q.
    always_comb begin
        txd_d = TXD_IDLE;
        unique case (state_d)
            IDLE:   txd_d = TXD_IDLE;
            START:  txd_d = TXD_START;
            DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd_d = parity_d;
`endif
            STOP:   txd_d = TXD_STOP;
            default: txd_d = TXD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            txd_q   <= TXD_IDLE;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
